// File: rtl/key_press_classifier_pkg.sv
// Shared types and default timing constants for the key gesture classifier.
package key_press_classifier_pkg;

    // Gesture FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    // Defaults for a 50 MHz system clock
    localparam int DEF_CNT_W         = 26;
    localparam int DEF_LONG_TICKS    = 50_000_000;  // 1 s
    localparam int DEF_DBL_GAP_TICKS = 12_500_000;  // 250 ms
    localparam int DEF_REPEAT_TICKS  = 5_000_000;   // 100 ms

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector on the debounced key level.
// The previous-level register resets to 1, so a key already held when reset
// releases produces no rise until it has been released and pressed again.
module key_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_rise
);

    logic r_key_prev;

    // Track last sampled key level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_key_prev <= 1'b1;
        else          r_key_prev <= i_key;
    end

    assign o_rise = i_key & ~r_key_prev;

endmodule

// File: rtl/key_press_classifier.sv
// Classifies key gestures into one-cycle pulses: short, double, long, repeat.
// One shared timer counts cycles in the current state and is cleared on every
// state entry; each state leaves at or before its threshold, so it never wraps.
// The key level is checked before the threshold, so a release on the
// threshold edge takes the level transition and emits nothing.
module key_press_classifier
    import key_press_classifier_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_TICKS    = DEF_LONG_TICKS,
    parameter int DBL_GAP_TICKS = DEF_DBL_GAP_TICKS,
    parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_pressed,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_MAX  = CNT_W'(DBL_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_TICKS - 1);

    logic             w_rise;
    state_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_short, r_double, r_long, r_repeat, r_busy;

    key_edge_detect u_edge (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_key   (key_pressed),
        .o_rise  (w_rise)
    );

    // Gesture FSM with shared timer and registered pulse/busy outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESS1;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    if (!key_pressed) begin
                        r_state <= ST_WAIT2;
                        r_timer <= '0;
                    end else if (r_timer == LONG_MAX) begin
                        r_state <= ST_LONG;
                        r_timer <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                ST_WAIT2: begin
                    if (key_pressed) begin
                        r_state <= ST_PRESS2;
                        r_timer <= '0;
                    end else if (r_timer == DBL_MAX) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_short <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (!key_pressed) begin
                        r_state  <= ST_IDLE;
                        r_timer  <= '0;
                        r_double <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (r_timer == LONG_MAX) begin
                        // held too long on the second tap: becomes a long press
                        r_state <= ST_LONG;
                        r_timer <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                ST_LONG: begin
                    if (!key_pressed) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_timer == REP_MAX) begin
                        r_timer  <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign double_press = r_double;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign busy         = r_busy;

endmodule
